// File: rtl/sync_mem32x8_pkg.sv
// Shared types and op decode for the 32x8 synchronous RAM and its driver interface.
package mem_pkg;

  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned DEPTH      = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_READ,
    OP_WRITE,
    OP_ERR
  } op_e;

  // Only a clean 1 counts as an asserted strobe; X/Z fall through to idle.
  function automatic op_e decode_op(logic rd, logic wr);
    op_e op;
    case ({rd, wr})
      2'b10:   op = OP_READ;
      2'b01:   op = OP_WRITE;
      2'b11:   op = OP_ERR;
      default: op = OP_IDLE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/sync_mem32x8_if.sv
// Signal bundle between the RAM and its driver, with per-cycle driver tasks.
interface mem_interface
  import mem_pkg::*;
(
  input logic clk
);

  logic  rst;
  logic  read;
  logic  write;
  addr_t addr;
  data_t data_in;
  data_t data_out;
  logic  err;

  modport mem (
    input  read,
    input  write,
    input  addr,
    input  data_in,
    output data_out,
    output err
  );

  // Each call is entered away from a rising edge, covers exactly one rising edge and
  // returns at the following falling edge with that edge's outputs.
  task automatic drive_cycle(input logic r, input logic rd, input logic wr, input addr_t a,
                             input data_t d, output data_t dout, output logic e);
    rst     = r;
    read    = rd;
    write   = wr;
    addr    = a;
    data_in = d;
    @(posedge clk);
    @(negedge clk);
    dout = data_out;
    e    = err;
  endtask

  task automatic write_mem(input addr_t a, input data_t d);
    data_t dout;
    logic  e;
    drive_cycle(1'b0, 1'b0, 1'b1, a, d, dout, e);
  endtask

  task automatic read_mem(input addr_t a, output data_t d);
    logic e;
    drive_cycle(1'b0, 1'b1, 1'b0, a, '0, d, e);
  endtask

  modport tb (
    input  clk,
    output rst,
    output read,
    output write,
    output addr,
    output data_in,
    input  data_out,
    input  err,
    import drive_cycle,
    import write_mem,
    import read_mem
  );

endinterface

// File: rtl/sync_mem32x8.sv
// Single-port 32x8 synchronous RAM with registered read data and a per-cycle error flag
// for simultaneous read and write requests.
module sync_mem32x8
  import mem_pkg::*;
(
  input logic      clk,
  input logic      rst,
  mem_interface.mem bus
);

  data_t mem_q [DEPTH];
  data_t data_out_q;
  logic  err_q;
  op_e   op;

  always_comb begin
    op = decode_op(bus.read, bus.write);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      data_out_q <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= (op == OP_ERR);
      if (op == OP_WRITE) begin
        mem_q[bus.addr] <= bus.data_in;
      end
      if (op == OP_READ) begin
        data_out_q <= mem_q[bus.addr];
      end
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_sync_mem32x8.sv
// Directed self-checking bench for sync_mem32x8 using the interface driver tasks.
module tb_sync_mem32x8;
  import mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  mem_interface bus (.clk(clk));

  sync_mem32x8 dut (
    .clk (clk),
    .rst (bus.rst),
    .bus (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    data_t dout;
    logic  e;

    // Reset state
    bus.drive_cycle(1'b1, 1'b0, 1'b0, 5'd0, 8'h00, dout, e);
    check("reset_dout", 32'(dout), 32'h00);
    check("reset_err", 32'(e), 32'h0);

    // Reset clear
    for (int i = 0; i < DEPTH; i++) bus.write_mem(addr_t'(i), 8'hFF);
    bus.read_mem(5'd9, dout);
    check("prefill_rd9", 32'(dout), 32'hFF);
    bus.drive_cycle(1'b1, 1'b0, 1'b0, 5'd0, 8'h00, dout, e);
    check("clr_dout", 32'(dout), 32'h00);
    for (int i = 0; i < DEPTH; i++) begin
      bus.drive_cycle(1'b0, 1'b1, 1'b0, addr_t'(i), 8'h00, dout, e);
      check($sformatf("clr_rd[%0d]", i), 32'(dout), 32'h00);
      check($sformatf("clr_err[%0d]", i), 32'(e), 32'h0);
    end

    // Address walk
    for (int i = 0; i < DEPTH; i++) bus.write_mem(addr_t'(i), data_t'(i));
    for (int i = 0; i < DEPTH; i++) begin
      bus.read_mem(addr_t'(i), dout);
      check($sformatf("walk_rd[%0d]", i), 32'(dout), 32'(i));
    end

    // Data patterns and read-after-write on the next edge
    bus.write_mem(5'h0A, 8'h55);
    bus.read_mem(5'h0A, dout);
    check("pat_55", 32'(dout), 32'h55);
    bus.write_mem(5'h0A, 8'hAA);
    bus.read_mem(5'h0A, dout);
    check("pat_AA", 32'(dout), 32'hAA);
    bus.write_mem(5'h1F, 8'h81);
    bus.read_mem(5'h1F, dout);
    check("pat_top", 32'(dout), 32'h81);
    bus.write_mem(5'h00, 8'h3C);
    check("wr_holds_dout", 32'(bus.data_out), 32'h81);
    bus.read_mem(5'h00, dout);
    check("pat_bottom", 32'(dout), 32'h3C);

    // Hold over idle cycles
    bus.read_mem(5'd3, dout);
    check("hold_rd3", 32'(dout), 32'h03);
    for (int i = 0; i < 5; i++) begin
      bus.drive_cycle(1'b0, 1'b0, 1'b0, addr_t'(i + 10), 8'hEE, dout, e);
      check($sformatf("hold_dout[%0d]", i), 32'(dout), 32'h03);
      check($sformatf("hold_err[%0d]", i), 32'(e), 32'h0);
    end
    bus.read_mem(5'd3, dout);
    check("hold_mem3", 32'(dout), 32'h03);
    bus.read_mem(5'd12, dout);
    check("hold_mem12", 32'(dout), 32'h0C);

    // Illegal request: flag for one cycle only, no access
    bus.read_mem(5'd1, dout);
    check("ill_pre", 32'(dout), 32'h01);
    bus.drive_cycle(1'b0, 1'b1, 1'b1, 5'd4, 8'h99, dout, e);
    check("ill_err", 32'(e), 32'h1);
    check("ill_dout", 32'(dout), 32'h01);
    bus.drive_cycle(1'b0, 1'b0, 1'b0, 5'd4, 8'h99, dout, e);
    check("ill_err_clr", 32'(e), 32'h0);
    check("ill_dout_hold", 32'(dout), 32'h01);
    bus.read_mem(5'd4, dout);
    check("ill_mem4", 32'(dout), 32'h04);
    bus.drive_cycle(1'b0, 1'b1, 1'b1, 5'd4, 8'h99, dout, e);
    check("ill2_err", 32'(e), 32'h1);
    bus.write_mem(5'd5, 8'h66);
    check("ill2_err_wr", 32'(bus.err), 32'h0);

    // Reset wins over a simultaneous write
    bus.drive_cycle(1'b1, 1'b0, 1'b1, 5'd7, 8'h77, dout, e);
    check("rstwr_dout", 32'(dout), 32'h00);
    check("rstwr_err", 32'(e), 32'h0);
    bus.read_mem(5'd7, dout);
    check("rstwr_mem7", 32'(dout), 32'h00);
    bus.read_mem(5'd4, dout);
    check("rstwr_mem4", 32'(dout), 32'h00);
    bus.write_mem(5'd7, 8'h5A);
    bus.read_mem(5'd7, dout);
    check("post_rst_rw", 32'(dout), 32'h5A);

    bus.drive_cycle(1'b0, 1'b0, 1'b0, 5'd0, 8'h00, dout, e);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_mem32x8.md
Name: sync_mem32x8

Overview:
- Single-port synchronous RAM: 32 words x 8 bits, one clock, registered read data.
- Leaf storage block of the memory subsystem. The testbench/driver side reaches it through the mem_interface signal bundle.
- The interface's clock is the block's clock. All ports below are the interface signals as seen by the memory.

Parameters:
- ADDR_WIDTH, 5, address bits; DEPTH = 2**ADDR_WIDTH (32).
- DATA_WIDTH, 8, word width in bits.

Ports:
- clk  input  1  system clock; all state changes on rising edge only.
- rst  input  1  synchronous reset, active-high.
- read  input  1  read strobe; sampled at rising clk.
- write  input  1  write strobe; sampled at rising clk.
- addr  input  ADDR_WIDTH  word address, 0..DEPTH-1.
- data_in  input  DATA_WIDTH  write data.
- data_out  output  DATA_WIDTH  registered read data.
- err  output  1  registered error flag for an illegal request.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - At a rising clk with rst=1: every storage location is cleared to 0, data_out becomes 0 and err becomes 0.
  - rst overrides read and write in the same cycle; no access is performed.
- Write (write=1, read=0):
  - mem[addr] <= data_in at the rising edge.
  - data_out holds its previous value. err <= 0.
- Read (read=1, write=0):
  - data_out <= mem[addr] at the rising edge.
  - One-cycle latency: the value is valid after the edge that sampled read and stays until the next read or reset.
  - err <= 0.
- Idle (read=0, write=0): storage and data_out hold; err <= 0.
- Illegal request (read=1 and write=1):
  - No write and no read; storage and data_out hold.
  - err <= 1 for that cycle only. err is level per cycle, not sticky.
- Read-after-write:
  - A write at edge N to address A, followed by a read of A sampled at edge N+1, returns the new data at N+1.
  - There is no same-edge write-through.
- Address range: every 5-bit address is valid; no wrap or out-of-range handling is needed. If ADDR_WIDTH is changed, DEPTH follows.
- Unknown inputs: X/Z on read or write is not required to be handled. Implementations treat any non-1 value as 0.
- Reset mid-operation: a request presented in the same cycle as rst=1 is discarded. The cycle after reset deassertion behaves normally.
- No combinational path from any input to data_out or err.

Decomposition:
- Shared package mem_pkg holds:
  - ADDR_WIDTH/DATA_WIDTH defaults;
  - addr_t and data_t typedefs;
  - an enum op_e {OP_IDLE, OP_READ, OP_WRITE, OP_ERR} for decoding (read, write).
- mem_interface carries clk, rst, read, write, addr, data_in, data_out and err.
  - Modports: mem (the memory side) and tb (the driver side).
  - Driver tasks write_mem(addr, data) and read_mem(addr, data) each drive one access per clock and return after the data_out edge.
- No sub-module: op decode and storage array live in sync_mem32x8.

Test Plan:
- Reset clear: write 0xFF to all 32 addresses, pulse rst for 1 cycle, read all addresses -> every data_out = 0x00, err = 0.
- Address walk: write data = addr (0x00..0x1F) to each address, then read back in order -> data_out equals addr each cycle, 1-cycle latency, 0 mismatches.
- Data patterns: at addr 0x0A write 0x55, read; write 0xAA, read -> 0x55 then 0xAA. At addr 0x1F (top) write 0x81 -> reads 0x81.
- Hold: read addr 3 (value 0x03), then idle 5 cycles with addr changing and data_in=0xEE -> data_out stays 0x03, mem[3] unchanged.
- Illegal request: addr 4 holds 0x04; drive read=1, write=1, addr=4, data_in=0x99 -> err=1 for exactly one cycle, data_out unchanged, subsequent read of 4 returns 0x04.
- Reset vs access: assert rst together with write=1, addr=7, data_in=0x77 -> next read of 7 returns 0x00; data_out=0 and err=0 after the reset edge.
